svi_cas_player: RTL and testbench



---
 rtl/svi_cas_player_if.sv | 26 ++
 rtl/svi_cas_player.sv | 159 +++++++++++++++
 tb/tb_svi_cas_player.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/svi_cas_player_if.sv
// Cassette player bus: buffer RAM read port, transport controls
// and tape/OSD outputs. master = player, slave = environment.
interface svi_cas_player_if #(
  parameter int ADDR_W = 18
);
  logic              ce;
  logic              play;
  logic              rewind;
  logic [ADDR_W-1:0] length;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_data;
  logic              data;
  logic [2:0]        status;
  logic [ADDR_W-1:0] byte_count;

  modport master (
    input  ce, play, rewind, length, mem_data,
    output mem_addr, mem_rd, data, status, byte_count
  );

  modport slave (
    output ce, play, rewind, length, mem_data,
    input  mem_addr, mem_rd, data, status, byte_count
  );
endinterface

// File: rtl/svi_cas_player.sv
// SVI cassette playback: fetches CAS buffer bytes, frames them and
// FSK-encodes the 1200-baud tape signal, gated by the motor line.
module svi_cas_player #(
  parameter int ADDR_W    = 18,
  parameter int HALF0     = 8889,
  parameter int HALF1     = 4444,
  parameter int STOP_BITS = 2
) (
  input  logic clk,
  input  logic reset,
  svi_cas_player_if.master bus
);

  localparam int FRAME_W = 9 + STOP_BITS;
  localparam int HMAX    = (HALF0 > HALF1) ? HALF0 : HALF1;
  localparam int CNT_W   = (HMAX < 2) ? 1 : $clog2(HMAX);
  localparam int BIT_W   = $clog2(FRAME_W + 1);

  localparam logic [CNT_W-1:0] H0V = CNT_W'(HALF0 - 1);
  localparam logic [CNT_W-1:0] H1V = CNT_W'(HALF1 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SHIFT,
    S_PAUSED,
    S_END
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]  len_q, len_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0]   half_q, half_d;
  logic [1:0]         hidx_q, hidx_d;
  logic [BIT_W-1:0]   bits_q, bits_d;
  logic               data_q, data_d;
  logic [ADDR_W-1:0]  nxt_addr;
  logic [1:0]         last_half;
  logic [2:0]         status;

  assign nxt_addr  = addr_q + ADDR_W'(1);
  assign last_half = frame_q[0] ? 2'd3 : 2'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      frame_q <= '0;
      half_q  <= '0;
      hidx_q  <= '0;
      bits_q  <= '0;
      data_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      frame_q <= frame_d;
      half_q  <= half_d;
      hidx_q  <= hidx_d;
      bits_q  <= bits_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    frame_d = frame_q;
    half_d  = half_q;
    hidx_d  = hidx_q;
    bits_d  = bits_q;
    data_d  = data_q;
    if (bus.rewind) begin
      state_d = S_IDLE;
      addr_d  = '0;
      cnt_d   = '0;
      len_d   = '0;
      frame_d = '0;
      half_d  = '0;
      hidx_d  = '0;
      bits_d  = '0;
      data_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.play)
            state_d = (addr_q >= bus.length) ? S_END : S_FETCH;
        end
        S_FETCH: begin
          len_d   = bus.length;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          frame_d = {{STOP_BITS{1'b1}}, bus.mem_data, 1'b0};
          half_d  = H0V;
          hidx_d  = '0;
          bits_d  = BIT_W'(FRAME_W);
          state_d = bus.play ? S_SHIFT : S_PAUSED;
        end
        S_SHIFT: begin
          // pause wins over a coincident tick
          if (!bus.play) begin
            state_d = S_PAUSED;
          end else if (bus.ce) begin
            if (half_q != '0) begin
              half_d = half_q - CNT_W'(1);
            end else begin
              data_d = ~data_q;
              if (hidx_q != last_half) begin
                hidx_d = hidx_q + 2'd1;
                half_d = frame_q[0] ? H1V : H0V;
              end else if (bits_q != BIT_W'(1)) begin
                frame_d = frame_q >> 1;
                bits_d  = bits_q - BIT_W'(1);
                hidx_d  = '0;
                half_d  = frame_q[1] ? H1V : H0V;
              end else begin
                addr_d  = nxt_addr;
                cnt_d   = cnt_q + ADDR_W'(1);
                state_d = (nxt_addr >= len_q) ? S_END : S_FETCH;
              end
            end
          end
        end
        S_PAUSED: begin
          if (bus.play)
            state_d = S_SHIFT;
        end
        S_END: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    status = 3'd0;
    unique case (state_q)
      S_FETCH, S_WAIT, S_SHIFT: status = 3'd1;
      S_PAUSED:                 status = 3'd2;
      S_END:                    status = 3'd3;
      default:                  status = 3'd0;
    endcase
  end

  assign bus.mem_addr   = addr_q;
  assign bus.mem_rd     = (state_q == S_FETCH);
  assign bus.data       = data_q;
  assign bus.status     = status;
  assign bus.byte_count = cnt_q;

endmodule

// File: tb/tb_svi_cas_player.sv
// Bench for svi_cas_player: tick-level tape model plus directed
// and random transport stimulus.
module tb_svi_cas_player;

  localparam int AW = 8;
  localparam int H0 = 8;
  localparam int H1 = 4;
  localparam int SB = 2;
  localparam int FW = 9 + SB;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  svi_cas_player_if #(.ADDR_W(AW)) bus ();

  svi_cas_player #(
    .ADDR_W(AW),
    .HALF0(H0),
    .HALF1(H1),
    .STOP_BITS(SB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [7:0] mem [0:255];

  always @(posedge clk)
    if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];

  int tests = 0;
  int fails = 0;
  int rd_count = 0;

  typedef enum {M_IDLE, M_FETCH, M_WAIT, M_RUN, M_PAUSE, M_END} mph_t;
  mph_t       ph = M_IDLE;
  int         m_addr = 0;
  int         m_cnt = 0;
  int         m_len = 0;
  int         m_ticks = 0;
  logic [7:0] m_byte = 8'h00;
  logic       m_data = 1'b0;

  function automatic logic [FW-1:0] frame_of(logic [7:0] b);
    return {{SB{1'b1}}, b, 1'b0};
  endfunction

  function automatic int frame_ticks(logic [7:0] b);
    logic [FW-1:0] f;
    int t;
    f = frame_of(b);
    t = 0;
    for (int i = 0; i < FW; i++) t += f[i] ? 4 * H1 : 2 * H0;
    return t;
  endfunction

  // level = parity of completed half-periods after t ticks
  function automatic logic level_at(logic [7:0] b, int t);
    logic [FW-1:0] f;
    int rem, halves, h, n;
    bit done;
    f = frame_of(b);
    rem = t;
    halves = 0;
    done = 0;
    for (int i = 0; i < FW; i++) begin
      if (!done) begin
        h = f[i] ? H1 : H0;
        n = f[i] ? 4 : 2;
        if (rem >= n * h) begin
          rem -= n * h;
          halves += n;
        end else begin
          halves += rem / h;
          done = 1;
        end
      end
    end
    return halves[0];
  endfunction

  function automatic int exp_status(mph_t p);
    case (p)
      M_FETCH, M_WAIT, M_RUN: return 1;
      M_PAUSE:                return 2;
      M_END:                  return 3;
      default:                return 0;
    endcase
  endfunction

  task automatic m_clear();
    ph = M_IDLE;
    m_addr = 0;
    m_cnt = 0;
    m_len = 0;
    m_ticks = 0;
    m_data = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset || bus.rewind) begin
        m_clear();
      end else begin
        case (ph)
          M_IDLE:
            if (bus.play)
              ph = (m_addr >= int'(bus.length)) ? M_END : M_FETCH;
          M_FETCH: begin
            m_len = int'(bus.length);
            ph = M_WAIT;
          end
          M_WAIT: begin
            m_byte = mem[m_addr[7:0]];
            m_ticks = 0;
            ph = bus.play ? M_RUN : M_PAUSE;
          end
          M_RUN:
            if (!bus.play) begin
              ph = M_PAUSE;
            end else if (bus.ce) begin
              m_ticks++;
              m_data = level_at(m_byte, m_ticks);
              if (m_ticks == frame_ticks(m_byte)) begin
                m_addr++;
                m_cnt++;
                ph = (m_addr >= m_len) ? M_END : M_FETCH;
              end
            end
          M_PAUSE:
            if (bus.play) ph = M_RUN;
          default: ;
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_rd) rd_count++;
      tests++;
      if (int'(bus.mem_addr) != m_addr || int'(bus.byte_count) != m_cnt ||
          bus.data != m_data || int'(bus.status) != exp_status(ph) ||
          bus.mem_rd != (ph == M_FETCH)) begin
        fails++;
        $display("FAIL cycle t=%0t got addr=%0d cnt=%0d data=%0b st=%0d rd=%0b exp addr=%0d cnt=%0d data=%0b st=%0d rd=%0b",
                 $time, bus.mem_addr, bus.byte_count, bus.data, bus.status,
                 bus.mem_rd, m_addr, m_cnt, m_data, exp_status(ph),
                 ph == M_FETCH);
      end
    end
  end

  task automatic chk(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_rewind();
    bus.rewind = 1'b1;
    tick(1);
    bus.rewind = 1'b0;
  endtask

  task automatic wait_end(string name, int budget);
    int i;
    i = 0;
    while (bus.status != 3'd3 && i < budget) begin
      tick(1);
      i++;
    end
    chk(name, int'(bus.status), 3);
  endtask

  initial begin
    logic d0;
    bit changed;
    int i;
    bus.ce = 1'b0;
    bus.play = 1'b0;
    bus.rewind = 1'b0;
    bus.length = '0;
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;
    #1 reset = 1'b1;
    tick(3);
    chk("rst_addr", int'(bus.mem_addr), 0);
    chk("rst_rd", int'(bus.mem_rd), 0);
    chk("rst_data", int'(bus.data), 0);
    chk("rst_status", int'(bus.status), 0);
    chk("rst_count", int'(bus.byte_count), 0);
    chk("pin_frame_a5", int'(frame_of(8'hA5)), 'b11101001010);
    chk("pin_frame_3c", int'(frame_of(8'h3C)), 'b11001111000);
    chk("pin_ticks_00", frame_ticks(8'h00), 176);
    chk("pin_lvl_00_7", int'(level_at(8'h00, 7)), 0);
    chk("pin_lvl_00_8", int'(level_at(8'h00, 8)), 1);
    chk("pin_lvl_ff_20", int'(level_at(8'hFF, 20)), 1);
    reset = 1'b0;

    // single zero byte
    mem[0] = 8'h00;
    bus.length = AW'(1);
    bus.ce = 1'b1;
    rd_count = 0;
    bus.play = 1'b1;
    wait_end("t1_end", 400);
    chk("t1_count", int'(bus.byte_count), 1);
    chk("t1_addr", int'(bus.mem_addr), 1);
    chk("t1_reads", rd_count, 1);

    // two bytes
    bus.play = 1'b0;
    do_rewind();
    mem[0] = 8'hA5;
    mem[1] = 8'h3C;
    bus.length = AW'(2);
    rd_count = 0;
    bus.play = 1'b1;
    wait_end("t2_end", 800);
    chk("t2_count", int'(bus.byte_count), 2);
    chk("t2_addr", int'(bus.mem_addr), 2);
    chk("t2_reads", rd_count, 2);

    // pause 3 ticks into a '1' half-period
    bus.play = 1'b0;
    do_rewind();
    mem[0] = 8'hFF;
    bus.length = AW'(1);
    bus.play = 1'b1;
    i = 0;
    while (!(ph == M_RUN && m_ticks == 19) && i < 100) begin
      tick(1);
      i++;
    end
    chk("t3_reach", m_ticks, 19);
    bus.play = 1'b0;
    tick(1);
    chk("t3_status", int'(bus.status), 2);
    d0 = bus.data;
    changed = 0;
    for (int k = 0; k < 50; k++) begin
      tick(1);
      if (bus.data != d0) changed = 1;
    end
    chk("t3_frozen", int'(changed), 0);
    bus.play = 1'b1;
    tick(1);
    chk("t3_resume", int'(bus.data), int'(d0));
    tick(1);
    chk("t3_rem_half", int'(bus.data), int'(!d0));
    wait_end("t3_end", 400);

    // rewind mid byte 2
    bus.play = 1'b0;
    do_rewind();
    mem[0] = 8'h11;
    mem[1] = 8'h22;
    mem[2] = 8'h33;
    bus.length = AW'(3);
    bus.play = 1'b1;
    i = 0;
    while (!(m_addr == 1 && ph == M_RUN && m_ticks == 50) && i < 1000) begin
      tick(1);
      i++;
    end
    chk("t4_reach", m_addr, 1);
    do_rewind();
    chk("t4_addr", int'(bus.mem_addr), 0);
    chk("t4_count", int'(bus.byte_count), 0);
    chk("t4_data", int'(bus.data), 0);
    tick(1);
    chk("t4_refetch", int'(bus.mem_rd), 1);
    chk("t4_refetch_addr", int'(bus.mem_addr), 0);
    wait_end("t4_end", 1500);
    chk("t4_final", int'(bus.byte_count), 3);

    // empty buffer
    bus.play = 1'b0;
    do_rewind();
    bus.length = '0;
    rd_count = 0;
    bus.play = 1'b1;
    tick(2);
    chk("t5_status", int'(bus.status), 3);
    tick(10);
    chk("t5_reads", rd_count, 0);

    // async reset during WAIT
    bus.play = 1'b0;
    do_rewind();
    mem[0] = 8'h5A;
    bus.length = AW'(1);
    bus.play = 1'b1;
    i = 0;
    while (!bus.mem_rd && i < 10) begin
      tick(1);
      i++;
    end
    chk("t6_fetch", int'(bus.mem_rd), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_vals", int'({bus.mem_addr, bus.mem_rd, bus.data,
                             bus.status, bus.byte_count}), 0);
    @(negedge clk);
    bus.play = 1'b0;
    reset = 1'b0;
    tick(3);
    chk("t6_idle", int'(bus.status), 0);
    chk("t6_data", int'(bus.data), 0);

    // random transport
    bus.play = 1'b1;
    for (int c = 0; c < 30000; c++) begin
      bus.ce = ($urandom_range(99) < 70);
      bus.rewind = 1'b0;
      if ($urandom_range(399) == 0) bus.play = !bus.play;
      if ($urandom_range(2999) == 0) bus.length = AW'($urandom_range(8));
      if (c == 0 || $urandom_range(2499) == 0) begin
        bus.rewind = 1'b1;
        for (int k = 0; k < 16; k++) mem[k] = 8'($urandom);
        bus.length = ($urandom_range(9) == 0) ? '0 : AW'($urandom_range(1, 6));
      end
      tick(1);
    end
    bus.rewind = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
